conv1_window_gen: RTL and testbench
===================================

# conv1_window_gen

Streaming 3x3 window generator feeding the conv1 MAC processing element. It accepts the input image one pixel per beat, with all input channels packed into each pixel, in row-major order. It stores the two previous rows in line buffers and emits one zero-padded 3x3xC window per stride-2 output position. Its output drives the PE's window data input, and its `out_ready` is driven by the PE's `pe_ready`.

## Interface
Parameters:
- pDATA_WIDTH, 8, bits per channel sample
- pIN_CHANNEL, 3, channels packed per pixel
- pINPUT_WIDTH, 224, pixels per row; must be even
- pINPUT_HEIGHT, 224, rows per frame; must be even
- pKERNEL_SIZE, 3, fixed at 3; any other value is an elaboration error
- pPADDING, 1, fixed at 1
- pSTRIDE, 2, fixed at 2; elaboration assertion on any other value

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept the pixel this cycle
- in_data  in  pDATA_WIDTH*pIN_CHANNEL  pixel; channel ch at bits [ch*pDATA_WIDTH +: pDATA_WIDTH]
- out_valid  out  1  window valid
- out_ready  in  1  consumer accepts the window
- out_data  out  pDATA_WIDTH*pIN_CHANNEL*9  window
  - tap p = ky*3+kx, with ky=0 the top row and kx=0 the left column, at bits [p*C*8 +: C*8]
  - channel ch within a tap at +ch*8
- out_last  out  1  qualifies the final window of the frame
- frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted

## Operation
- Counters:
  - col counts 0..W-1 and row counts 0..H-1, both advanced on each accept (in_valid && in_ready).
  - Both wrap to 0 after pixel (H-1, W-1); frames are processed back to back with no idle cycle required.
- Line buffers:
  - lb0 holds row r-1 and lb1 holds row r-2, each of depth W, width C*8.
  - Combinational read at index col.
  - On accept: lb1[col] <= lb0[col] and lb0[col] <= in_data.
- Window shift register (3 columns x 3 rows):
  - On accept it shifts left and loads the new right column {top=lb1[col], mid=lb0[col], bottom=in_data}.
  - Top padding: when row==0, top and mid are forced to 0. When row==1, top is forced to 0.
  - Left padding: at col==0 the two older columns are cleared before the shift, so the window for ox=0 has a zero left column.
- Emission:
  - A window is emitted when a pixel is accepted with row odd and col odd.
  - Its centre is input (row-1, col-1), i.e. output position (oy, ox) = ((row-1)/2, (col-1)/2).
  - Emission loads out_data from the post-shift window and sets out_valid.
  - With even W and H, right and bottom padding never occur.
- Output handshake:
  - out_valid stays high and out_data stays stable until out_valid && out_ready, then out_valid clears.
  - A new emission in the same cycle as a consume reloads the register and keeps out_valid high.
- Backpressure: in_ready = !out_valid || out_ready. in_ready is combinational and does not depend on in_valid.
- out_last is set with the window for oy=H/2-1, ox=W/2-1.
- Window count per frame is (H/2)*(W/2), i.e. 12544 at default parameters.
- Reset mid-frame:
  - Counters, shift register, out_valid, out_last and frame_done all clear.
  - Line buffer contents are don't-care; the padding forcing masks stale data.
  - The next accepted pixel is (0,0).

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_last=0, frame_done=0.
  - in_ready=1, since it follows from out_valid=0.
- Latency: the window is visible on out_data/out_valid in the cycle after the accept of its triggering pixel.
- Throughput: one pixel per cycle while out_ready stays high.
- Stall: with out_valid=1 and out_ready=0, in_ready=0 and no state advances.
- frame_done is high in the cycle after the accept of pixel (H-1, W-1), coincident with the out_valid rise of the out_last window.

## Structure
- Package conv1_win_pkg:
  - localparam KERNEL=3.
  - PIX_W = pDATA_WIDTH*pIN_CHANNEL.
  - Window tap index function.
- Sub-module conv1_line_buffer:
  - Single line: depth W, async read, sync write.
  - Instantiated twice (lb0, lb1).

## Test plan
- W=H=4, C=1, pixel value = row*4+col+1, out_ready=1:
  - Exactly 4 windows emitted.
  - Window (0,0) taps = {0,0,0, 0,1,2, 0,5,6}.
  - Window (1,1) taps = {6,7,8, 10,11,12, 14,15,16}.
  - out_last only on the 4th window.
- Same stimulus with out_ready held 0 for 5 cycles after the first window:
  - in_ready=0 throughout the hold.
  - out_data is unchanged for all 5 cycles.
  - Windows are identical to the no-stall run.
- Default 224x224, C=3, random data, random in_valid/out_ready:
  - 12544 windows match a software model of pad-1/stride-2 im2col.
  - frame_done pulses once.
- Two back-to-back 4x4 frames with no gap:
  - The second frame's windows are correct; no row-1 data leaks into the top padding.
- rst asserted after 7 accepts, then a fresh frame is driven:
  - Outputs return to reset values the next cycle.
  - The fresh frame reproduces the first test's windows.
- Simultaneous consume and emit (out_ready=1 while a new window is triggered):
  - out_valid stays high with the new data; no window is dropped or duplicated.

Source files
------------

// File: rtl/conv1_win_pkg.sv
// Shared constants and helpers for the conv1 3x3 window generator.
package conv1_win_pkg;

    localparam int KERNEL = 3;
    localparam int TAPS   = KERNEL * KERNEL;

    function automatic int pix_w(input int data_width, input int channels);
        return data_width * channels;
    endfunction

    // Tap ordering is row-major with ky=0 the top row and kx=0 the left column.
    function automatic int tap_index(input int ky, input int kx);
        return ky * KERNEL + kx;
    endfunction

endpackage

// File: rtl/conv1_line_buffer.sv
// One image row of pixel storage: asynchronous read and synchronous write at the same index.
module conv1_line_buffer #(
    parameter int pDEPTH = 224,
    parameter int pWIDTH = 24,
    localparam int AW    = $clog2(pDEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     addr,
    input  logic [pWIDTH-1:0] wr_data,
    output logic [pWIDTH-1:0] rd_data
);

    logic [pWIDTH-1:0] mem_q [pDEPTH];

    // NOTE: the storage has no reset; the top-row padding masks whatever a previous frame left here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[addr];

endmodule

// File: rtl/conv1_window_gen.sv
// Streaming zero-padded 3x3xC, stride-2 window generator for the conv1 PE.
module conv1_window_gen
    import conv1_win_pkg::*;
#(
    parameter int pDATA_WIDTH   = 8,
    parameter int pIN_CHANNEL   = 3,
    parameter int pINPUT_WIDTH  = 224,
    parameter int pINPUT_HEIGHT = 224,
    parameter int pKERNEL_SIZE  = 3,
    parameter int pPADDING      = 1,
    parameter int pSTRIDE       = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [pDATA_WIDTH*pIN_CHANNEL-1:0]         in_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [pDATA_WIDTH*pIN_CHANNEL*TAPS-1:0]    out_data,
    output logic                                       out_last,
    output logic                                       frame_done
);

    localparam int PIX_W = pix_w(pDATA_WIDTH, pIN_CHANNEL);
    localparam int CW    = $clog2(pINPUT_WIDTH);
    localparam int RW    = $clog2(pINPUT_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(pINPUT_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(pINPUT_HEIGHT - 1);

    if (pKERNEL_SIZE != KERNEL) begin : g_bad_kernel
        $error("conv1_window_gen: pKERNEL_SIZE must be 3");
    end
    if (pSTRIDE != 2) begin : g_bad_stride
        $error("conv1_window_gen: pSTRIDE must be 2");
    end
    if (pPADDING != 1) begin : g_bad_padding
        $error("conv1_window_gen: pPADDING must be 1");
    end
    if ((pINPUT_WIDTH % 2 != 0) || (pINPUT_HEIGHT % 2 != 0)) begin : g_bad_size
        $error("conv1_window_gen: image width and height must be even");
    end

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [PIX_W-1:0] win_q [KERNEL][KERNEL];
    logic [PIX_W-1:0] win_d [KERNEL][KERNEL];
    logic [PIX_W-1:0] new_col [KERNEL];
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             frame_done_q, frame_done_d;
    logic [PIX_W*TAPS-1:0] out_data_q, out_data_d;

    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic             accept, emit, col_last, row_last;

    // lb0 holds row r-1 and lb1 holds row r-2; both advance together on every accepted pixel.
    conv1_line_buffer #(.pDEPTH(pINPUT_WIDTH), .pWIDTH(PIX_W)) u_lb0 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col_q),
        .wr_data (in_data),
        .rd_data (lb0_rd)
    );

    conv1_line_buffer #(.pDEPTH(pINPUT_WIDTH), .pWIDTH(PIX_W)) u_lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col_q),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        accept   = in_valid && in_ready;
        col_last = (col_q == COL_LAST);
        row_last = (row_q == ROW_LAST);
        emit     = accept && row_q[0] && col_q[0];

        // Rows above the image are zero padding; this also hides stale line-buffer data.
        new_col[0] = ((row_q == '0) || (row_q == RW'(1))) ? '0 : lb1_rd;
        new_col[1] = (row_q == '0) ? '0 : lb0_rd;
        new_col[2] = in_data;

        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_last_d   = out_last_q && !out_ready;
        out_data_d   = out_data_q;
        frame_done_d = accept && row_last && col_last;

        if (accept) begin
            for (int ky = 0; ky < KERNEL; ky++) begin
                win_d[ky][0] = (col_q == '0) ? '0 : win_q[ky][1];
                win_d[ky][1] = (col_q == '0) ? '0 : win_q[ky][2];
                win_d[ky][2] = new_col[ky];
            end
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = row_last ? '0 : row_q + 1'b1;
            end
        end

        if (emit) begin
            out_valid_d = 1'b1;
            out_last_d  = row_last && col_last;
            for (int ky = 0; ky < KERNEL; ky++) begin
                for (int kx = 0; kx < KERNEL; kx++) begin
                    out_data_d[tap_index(ky, kx)*PIX_W +: PIX_W] = win_d[ky][kx];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            out_data_q   <= '0;
            for (int ky = 0; ky < KERNEL; ky++) begin
                for (int kx = 0; kx < KERNEL; kx++) begin
                    win_q[ky][kx] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            out_data_q   <= out_data_d;
            win_q        <= win_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv1_window_gen.sv
// Scoreboard bench: a 4x4 single-channel instance for directed cases and a default-size instance for a random frame.
module tb_conv1_window_gen;

    localparam int SW = 4;
    localparam int SH = 4;
    localparam int LW = 224;
    localparam int LH = 224;

    typedef struct {
        logic [255:0] data;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         s_rst, s_in_valid, s_in_ready, s_out_valid, s_out_last, s_frame_done;
    logic         s_out_ready;
    logic [7:0]   s_in_data;
    logic [71:0]  s_out_data;

    logic         l_rst, l_in_valid, l_in_ready, l_out_valid, l_out_last, l_frame_done;
    logic         l_out_ready = 1'b1;
    logic [23:0]  l_in_data;
    logic [215:0] l_out_data;

    conv1_window_gen #(
        .pDATA_WIDTH(8), .pIN_CHANNEL(1), .pINPUT_WIDTH(SW), .pINPUT_HEIGHT(SH),
        .pKERNEL_SIZE(3), .pPADDING(1), .pSTRIDE(2)
    ) u_small (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_last(s_out_last), .frame_done(s_frame_done)
    );

    conv1_window_gen u_large (
        .clk(clk), .rst(l_rst), .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .out_data(l_out_data),
        .out_last(l_out_last), .frame_done(l_frame_done)
    );

    exp_t        s_q[$];
    exp_t        l_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          s_win_cnt = 0, s_done_cnt = 0;
    int          l_win_cnt = 0, l_done_cnt = 0;
    logic [23:0] img [LH][LW];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pad-1 / stride-2 im2col reference; small-frame pixel value is base + row*SW + col + 1.
    function automatic logic [255:0] exp_small(input int oy, input int ox, input int base);
        logic [255:0] w;
        int iy, ix;
        w = '0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                iy = 2*oy + ky - 1;
                ix = 2*ox + kx - 1;
                if (iy >= 0 && iy < SH && ix >= 0 && ix < SW)
                    w[(ky*3+kx)*8 +: 8] = 8'(base + iy*SW + ix + 1);
            end
        end
        return w;
    endfunction

    function automatic logic [255:0] exp_large(input int oy, input int ox);
        logic [255:0] w;
        int iy, ix;
        w = '0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                iy = 2*oy + ky - 1;
                ix = 2*ox + kx - 1;
                if (iy >= 0 && iy < LH && ix >= 0 && ix < LW)
                    w[(ky*3+kx)*24 +: 24] = img[iy][ix];
            end
        end
        return w;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!s_rst) begin
            if (s_frame_done) begin
                s_done_cnt++;
                check("s_done_with_last", 256'({s_out_valid, s_out_last}), 256'd3);
            end
            if (s_out_valid && s_out_ready) begin
                s_win_cnt++;
                check("s_window_expected", 256'(s_q.size() > 0), 256'd1);
                if (s_q.size() > 0) begin
                    e = s_q.pop_front();
                    check("s_window", 256'(s_out_data), e.data);
                    check("s_last", 256'(s_out_last), 256'(e.last));
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!l_rst) begin
            if (l_frame_done) begin
                l_done_cnt++;
                check("l_done_with_last", 256'({l_out_valid, l_out_last}), 256'd3);
            end
            if (l_out_valid && l_out_ready) begin
                l_win_cnt++;
                check("l_window_expected", 256'(l_q.size() > 0), 256'd1);
                if (l_q.size() > 0) begin
                    e = l_q.pop_front();
                    check("l_window", 256'(l_out_data), e.data);
                    check("l_last", 256'(l_out_last), 256'(e.last));
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        l_out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic s_send(input int r, input int c, input int base);
        bit acc;
        int t;
        t = 0;
        s_in_valid = 1'b1;
        s_in_data  = 8'(base + r*SW + c + 1);
        if (r % 2 == 1 && c % 2 == 1)
            s_q.push_back('{data: exp_small((r-1)/2, (c-1)/2, base), last: (r == SH-1 && c == SW-1)});
        do begin
            @(negedge clk);
            acc = s_in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 50);
        check("s_accept", 256'(acc), 256'd1);
    endtask

    // Drives n_pix pixels of a small frame; in_valid is left high so frames can abut.
    task automatic s_frame(input int base, input int n_pix, input bit stall);
        logic [71:0] held;
        for (int i = 0; i < n_pix; i++) begin
            s_send(i / SW, i % SW, base);
            if (stall && i == 5) begin
                held        = s_out_data;
                s_out_ready = 1'b0;
                s_in_valid  = 1'b1;
                s_in_data   = 8'(base + 7);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall_in_ready", 256'(s_in_ready), 256'd0);
                    check("stall_out_valid", 256'(s_out_valid), 256'd1);
                    check("stall_out_data", 256'(s_out_data), 256'(held));
                    @(posedge clk);
                    #1;
                end
                check("stall_held_window", 256'(held), exp_small(0, 0, base));
                s_out_ready = 1'b1;
            end
        end
    endtask

    task automatic s_drain();
        for (int t = 0; t < 20 && s_q.size() > 0; t++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check("s_queue_empty", 256'(s_q.size()), 256'd0);
    endtask

    task automatic l_frame();
        bit acc;
        int t;
        for (int r = 0; r < LH; r++) begin
            for (int c = 0; c < LW; c++) begin
                if ($urandom_range(0, 9) == 0) begin
                    l_in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                l_in_valid = 1'b1;
                l_in_data  = img[r][c];
                if (r % 2 == 1 && c % 2 == 1)
                    l_q.push_back('{data: exp_large((r-1)/2, (c-1)/2), last: (r == LH-1 && c == LW-1)});
                t = 0;
                do begin
                    @(negedge clk);
                    acc = l_in_ready;
                    @(posedge clk);
                    #1;
                    t++;
                end while (!acc && t < 100);
                check("l_accept", 256'(acc), 256'd1);
            end
        end
        l_in_valid = 1'b0;
    endtask

    initial begin
        int w0, d0;
        s_rst = 1'b1;  l_rst = 1'b1;
        s_in_valid = 1'b0;  l_in_valid = 1'b0;
        s_in_data = '0;  l_in_data = '0;
        s_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 256'(s_out_valid), 256'd0);
        check("rst_out_data", 256'(s_out_data), 256'd0);
        check("rst_out_last", 256'(s_out_last), 256'd0);
        check("rst_frame_done", 256'(s_frame_done), 256'd0);
        check("rst_in_ready", 256'(s_in_ready), 256'd1);
        s_rst = 1'b0;  l_rst = 1'b0;

        // Basic 4x4 frame, consumer always ready.
        w0 = s_win_cnt;  d0 = s_done_cnt;
        s_frame(0, 16, 1'b0);
        s_in_valid = 1'b0;
        s_drain();
        check("basic_win_count", 256'(s_win_cnt - w0), 256'd4);
        check("basic_done_count", 256'(s_done_cnt - d0), 256'd1);

        // Same frame with a 5-cycle consumer stall after the first window.
        w0 = s_win_cnt;
        s_frame(0, 16, 1'b1);
        s_in_valid = 1'b0;
        s_drain();
        check("stall_win_count", 256'(s_win_cnt - w0), 256'd4);

        // Two frames with no gap between them.
        w0 = s_win_cnt;  d0 = s_done_cnt;
        s_frame(0, 16, 1'b0);
        s_frame(100, 16, 1'b0);
        s_in_valid = 1'b0;
        s_drain();
        check("b2b_win_count", 256'(s_win_cnt - w0), 256'd8);
        check("b2b_done_count", 256'(s_done_cnt - d0), 256'd2);

        // Reset after 7 accepts, then a fresh frame.
        s_frame(0, 7, 1'b0);
        s_in_valid = 1'b0;
        s_rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", 256'(s_out_valid), 256'd0);
        check("mid_rst_out_data", 256'(s_out_data), 256'd0);
        check("mid_rst_out_last", 256'(s_out_last), 256'd0);
        check("mid_rst_in_ready", 256'(s_in_ready), 256'd1);
        s_rst = 1'b0;
        s_q.delete();
        w0 = s_win_cnt;
        s_frame(0, 16, 1'b0);
        s_in_valid = 1'b0;
        s_drain();
        check("post_rst_win_count", 256'(s_win_cnt - w0), 256'd4);

        // Full-size random frame with random source gaps and consumer backpressure.
        for (int r = 0; r < LH; r++)
            for (int c = 0; c < LW; c++)
                img[r][c] = 24'($urandom());
        l_frame();
        for (int t = 0; t < 200 && l_q.size() > 0; t++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("l_queue_empty", 256'(l_q.size()), 256'd0);
        check("l_win_count", 256'(l_win_cnt), 256'd12544);
        check("l_done_count", 256'(l_done_cnt), 256'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
